// File: rtl/clock12_set_ctrl_if.sv
// Signal bundle between the time-set controller and its surroundings
// (button pulses and current time in, time-base load strobe and display hints out).
interface clock12_set_ctrl_if;
  logic       mode_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic [4:0] cur_hours;
  logic [5:0] cur_mins;
  logic       cur_ap;
  logic       start;
  logic [4:0] hours_load;
  logic [5:0] mins_load;
  logic [5:0] secs_load;
  logic       ap_load;
  logic       edit_active;
  logic [1:0] field_sel;
  logic       blink;
  logic       tick;

  modport master (
    output mode_btn, inc_btn, dec_btn, cur_hours, cur_mins, cur_ap,
    input  start, hours_load, mins_load, secs_load, ap_load,
    input  edit_active, field_sel, blink, tick
  );

  modport slave (
    input  mode_btn, inc_btn, dec_btn, cur_hours, cur_mins, cur_ap,
    output start, hours_load, mins_load, secs_load, ap_load,
    output edit_active, field_sel, blink, tick
  );
endinterface

// File: rtl/clock12_set_ctrl.sv
// Time-set controller for a 12-hour time-base: edits hour/minute/AM-PM from
// button pulses, commits with a one-cycle load strobe, and generates the 1 Hz tick.
module clock12_set_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  clock12_set_ctrl_if.slave     bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_S + 1);

  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_AP, COMMIT} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   tick_cnt_reg;
  logic [TO_W-1:0]    timeout_reg;
  logic [4:0]         edit_hr_reg;
  logic [5:0]         edit_min_reg;
  logic               edit_ap_reg;
  logic               start_reg;
  logic [4:0]         hours_load_reg;
  logic [5:0]         mins_load_reg;
  logic               ap_load_reg;
  logic               edit_active_reg;
  logic [1:0]         field_sel_reg;
  logic               blink_reg;

  logic               tick_w;
  logic               any_btn;
  logic               adj_one;
  logic               timeout_hit;
  logic [4:0]         cap_hr;
  logic [5:0]         cap_min;

  assign tick_w  = (tick_cnt_reg == CNT_W'(TICK_DIV - 1));
  assign any_btn = bus.mode_btn | bus.inc_btn | bus.dec_btn;
  // inc and dec together cancel out; only a lone press adjusts the field
  assign adj_one = bus.inc_btn ^ bus.dec_btn;
  assign timeout_hit = tick_w && !any_btn && (timeout_reg == TO_W'(TIMEOUT_S - 1));
  assign cap_hr  = (bus.cur_hours == 5'd0 || bus.cur_hours > 5'd12) ? 5'd12 : bus.cur_hours;
  assign cap_min = (bus.cur_mins > 6'd59) ? 6'd0 : bus.cur_mins;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if (tick_w) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      timeout_reg     <= '0;
      edit_hr_reg     <= 5'd1;
      edit_min_reg    <= 6'd0;
      edit_ap_reg     <= 1'b0;
      start_reg       <= 1'b0;
      hours_load_reg  <= 5'd0;
      mins_load_reg   <= 6'd0;
      ap_load_reg     <= 1'b0;
      edit_active_reg <= 1'b0;
      field_sel_reg   <= 2'd0;
      blink_reg       <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          blink_reg <= 1'b0;
          if (bus.mode_btn) begin
            edit_hr_reg     <= cap_hr;
            edit_min_reg    <= cap_min;
            edit_ap_reg     <= bus.cur_ap;
            timeout_reg     <= '0;
            state_reg       <= SET_HR;
            field_sel_reg   <= 2'd1;
            edit_active_reg <= 1'b1;
          end
        end

        SET_HR, SET_MIN, SET_AP: begin
          if (any_btn)
            timeout_reg <= '0;
          else if (tick_w)
            timeout_reg <= timeout_reg + TO_W'(1);
          if (tick_w)
            blink_reg <= ~blink_reg;

          if (bus.mode_btn) begin
            case (state_reg)
              SET_HR: begin
                state_reg     <= SET_MIN;
                field_sel_reg <= 2'd2;
              end
              SET_MIN: begin
                state_reg     <= SET_AP;
                field_sel_reg <= 2'd3;
              end
              default: begin
                // load values are captured here so they are stable while start is high
                state_reg       <= COMMIT;
                start_reg       <= 1'b1;
                hours_load_reg  <= edit_hr_reg - 5'd1;
                mins_load_reg   <= edit_min_reg;
                ap_load_reg     <= edit_ap_reg;
                field_sel_reg   <= 2'd0;
                edit_active_reg <= 1'b0;
                blink_reg       <= 1'b0;
              end
            endcase
          end else if (timeout_hit) begin
            state_reg       <= RUN;
            field_sel_reg   <= 2'd0;
            edit_active_reg <= 1'b0;
            blink_reg       <= 1'b0;
          end else if (adj_one) begin
            case (state_reg)
              SET_HR: begin
                if (bus.inc_btn)
                  edit_hr_reg <= (edit_hr_reg == 5'd12) ? 5'd1 : edit_hr_reg + 5'd1;
                else
                  edit_hr_reg <= (edit_hr_reg == 5'd1) ? 5'd12 : edit_hr_reg - 5'd1;
              end
              SET_MIN: begin
                if (bus.inc_btn)
                  edit_min_reg <= (edit_min_reg == 6'd59) ? 6'd0 : edit_min_reg + 6'd1;
                else
                  edit_min_reg <= (edit_min_reg == 6'd0) ? 6'd59 : edit_min_reg - 6'd1;
              end
              default: edit_ap_reg <= ~edit_ap_reg;
            endcase
          end
        end

        COMMIT: begin
          state_reg <= RUN;
          blink_reg <= 1'b0;
        end

        default: begin
          state_reg       <= RUN;
          field_sel_reg   <= 2'd0;
          edit_active_reg <= 1'b0;
          blink_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start       = start_reg;
  assign bus.hours_load  = hours_load_reg;
  assign bus.mins_load   = mins_load_reg;
  assign bus.secs_load   = 6'd0;
  assign bus.ap_load     = ap_load_reg;
  assign bus.edit_active = edit_active_reg;
  assign bus.field_sel   = field_sel_reg;
  assign bus.blink       = blink_reg;
  assign bus.tick        = tick_w;

endmodule

// File: tb/tb_clock12_set_ctrl.sv
// Directed bench for clock12_set_ctrl; commits are scoreboarded against a queue
// of expected load values filled as the edit sequences are driven.
module tb_clock12_set_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  clock12_set_ctrl_if bus ();

  clock12_set_ctrl #(.TICK_DIV(4), .TIMEOUT_S(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] mins;
    logic       ap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic blink_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    @(negedge clk);
    bus.mode_btn = m;
    bus.inc_btn  = i;
    bus.dec_btn  = d;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    bus.dec_btn  = 1'b0;
  endtask

  task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic a);
    bus.cur_hours = h;
    bus.cur_mins  = m;
    bus.cur_ap    = a;
  endtask

  // mode press from SET_AP: start must appear on the next cycle for exactly one cycle
  task automatic commit(input logic [4:0] h, input logic [5:0] m, input logic a);
    exp_t e;
    e.hours = h;
    e.mins  = m;
    e.ap    = a;
    exp_q.push_back(e);
    press(1'b1, 1'b0, 1'b0);
    check("start_pulse", bus.start, 1);
    check("commit_edit_active", bus.edit_active, 0);
    @(negedge clk);
    check("start_width", bus.start, 0);
    check("run_field_sel", bus.field_sel, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && bus.start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", bus.start, 0);
      end else begin
        e = exp_q.pop_front();
        $display("commit: hours_load=%0d mins_load=%0d secs_load=%0d ap_load=%0d (want %0d %0d 0 %0d)",
                 bus.hours_load, bus.mins_load, bus.secs_load, bus.ap_load, e.hours, e.mins, e.ap);
        check("hours_load", bus.hours_load, e.hours);
        check("mins_load", bus.mins_load, e.mins);
        check("secs_load", bus.secs_load, 0);
        check("ap_load", bus.ap_load, e.ap);
      end
    end
  end

  initial begin
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    bus.dec_btn  = 1'b0;
    set_cur(5'd11, 6'd58, 1'b0);
    reset = 1'b0;
    idle(2);

    // reset state
    check("rst_start", bus.start, 0);
    check("rst_hours_load", bus.hours_load, 0);
    check("rst_mins_load", bus.mins_load, 0);
    check("rst_secs_load", bus.secs_load, 0);
    check("rst_ap_load", bus.ap_load, 0);
    check("rst_edit_active", bus.edit_active, 0);
    check("rst_field_sel", bus.field_sel, 0);
    check("rst_blink", bus.blink, 0);
    check("rst_tick", bus.tick, 0);
    reset = 1'b1;

    // reset in the middle of an edit
    press(1'b1, 1'b0, 1'b0);
    check("enter_set_hr_field", bus.field_sel, 1);
    check("enter_set_hr_active", bus.edit_active, 1);
    press(1'b1, 1'b0, 1'b0);
    check("enter_set_min_field", bus.field_sel, 2);
    #2 reset = 1'b0;
    #1;
    check("midrst_field_sel", bus.field_sel, 0);
    check("midrst_edit_active", bus.edit_active, 0);
    check("midrst_start", bus.start, 0);
    check("midrst_blink", bus.blink, 0);
    check("midrst_tick", bus.tick, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1); check("tick_c1", bus.tick, 0);
    idle(1); check("tick_c2", bus.tick, 0);
    idle(1); check("tick_c3", bus.tick, 1);
    idle(1); check("tick_c4", bus.tick, 0);
    check("after_rst_field", bus.field_sel, 0);

    // full edit: 11:58 AM -> 12:00 PM
    set_cur(5'd11, 6'd58, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("set_ap_field", bus.field_sel, 3);
    press(1'b0, 1'b1, 1'b0);
    commit(5'd11, 6'd0, 1'b1);

    // wraps: hour 1 -dec-> 12 -inc-> 1, minute 0 -dec-> 59
    set_cur(5'd1, 6'd0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    commit(5'd0, 6'd59, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    commit(5'd11, 6'd0, 1'b0);

    // timeout abandons the edit without a start
    set_cur(5'd7, 6'd30, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("to_entry_field", bus.field_sel, 1);
    idle(12);
    check("to_edit_active", bus.edit_active, 0);
    check("to_field_sel", bus.field_sel, 0);
    check("to_blink", bus.blink, 0);

    // an inc press part-way through restarts the timeout
    press(1'b1, 1'b0, 1'b0);
    blink_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.blink === 1'b1) blink_seen = 1'b1;
    end
    press(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.blink === 1'b1) blink_seen = 1'b1;
    end
    check("to_extended_field", bus.field_sel, 1);
    check("blink_toggled", blink_seen, 1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    commit(5'd7, 6'd30, 1'b0);

    // simultaneous buttons
    set_cur(5'd5, 6'd20, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check("mode_inc_field", bus.field_sel, 2);
    idle(4);
    press(1'b0, 1'b1, 1'b1);
    idle(7);
    check("incdec_field", bus.field_sel, 2);
    check("incdec_active", bus.edit_active, 1);
    press(1'b1, 1'b0, 1'b0);
    commit(5'd4, 6'd20, 1'b1);

    // capture clamps
    set_cur(5'd0, 6'd63, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    commit(5'd11, 6'd0, 1'b1);
    set_cur(5'd15, 6'd10, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    commit(5'd11, 6'd10, 1'b0);

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock12_set_ctrl.md
Name: clock12_set_ctrl

Overview:
- Time-set controller for the 12-hour time-base counter.
- Sequences user editing of hour, minute and AM/PM from debounced button pulses.
- On commit, issues a one-cycle start pulse with load values to the time-base. Otherwise the time-base runs freely.
- Also generates the 1 Hz tick enable and the display blink/field-select signals.

Parameters:
- TICK_DIV, 100000000: clk cycles per tick (1 s).
- TIMEOUT_S, 30: ticks without a button press in an edit state before the edit is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mode_btn  in  1  single-cycle pulse, synchronous, debounced upstream
- inc_btn  in  1  single-cycle pulse
- dec_btn  in  1  single-cycle pulse
- cur_hours  in  5  current hour from time-base, 1..12
- cur_mins  in  6  current minute, 0..59
- cur_ap  in  1  current AM(0)/PM(1)
- start  out  1  one-cycle load strobe to time-base
- hours_load  out  5  hour load value = edit_hr - 1 (time-base adds 1 on load)
- mins_load  out  6  minute load value
- secs_load  out  6  seconds load value, always 0
- ap_load  out  1  AM/PM load value
- edit_active  out  1  high in any edit state
- field_sel  out  2  0 = none, 1 = hour, 2 = minute, 3 = AM/PM
- blink  out  1  display blink phase for the selected field
- tick  out  1  one-cycle pulse every TICK_DIV cycles

Behaviour:
- Reset (asynchronous, reset=0):
  - state = RUN, edit_hr = 1, edit_min = 0, edit_ap = 0.
  - tick counter = 0, timeout counter = 0, blink = 0.
  - Resulting outputs: start = 0, hours_load = 0, mins_load = 0, secs_load = 0, ap_load = 0, edit_active = 0, field_sel = 0, tick = 0.
  - Reset asserted mid-edit discards the edit; no start is issued.
- Tick divider:
  - Free-running counter 0..TICK_DIV-1, running in all states.
  - tick = 1 for the one cycle in which the counter equals TICK_DIV-1; the counter then wraps to 0.
- States: RUN, SET_HR, SET_MIN, SET_AP, COMMIT.
- RUN:
  - field_sel = 0, edit_active = 0, blink = 0.
  - mode_btn: capture cur_hours/cur_mins/cur_ap into edit registers, go to SET_HR.
  - A captured hour of 0 or >12 is clamped to 12; a captured minute >59 is clamped to 0.
  - inc_btn/dec_btn are ignored.
- SET_HR: field_sel = 1. inc: 12 -> 1, else +1. dec: 1 -> 12, else -1. mode_btn -> SET_MIN.
- SET_MIN: field_sel = 2. inc: 59 -> 0. dec: 0 -> 59. mode_btn -> SET_AP.
- SET_AP: field_sel = 3. inc or dec toggles edit_ap. mode_btn -> COMMIT.
- COMMIT:
  - Lasts exactly one cycle: start = 1, then RUN unconditionally.
  - Buttons in this cycle are ignored.
- Load outputs:
  - Registered from the edit registers and valid whenever start = 1.
  - They hold their last values in RUN.
  - start is registered and asserted only in COMMIT.
- Edit-state rules:
  - edit_active = 1 in SET_HR, SET_MIN and SET_AP.
  - blink toggles on each tick while edit_active; forced to 0 on entry to RUN.
  - mode_btn asserted with inc/dec in the same cycle: mode wins, inc/dec are ignored.
  - inc_btn and dec_btn asserted together: no change, but the timeout is still cleared.
- Timeout:
  - Counter cleared on any button pulse and on entry to SET_HR.
  - Increments on tick while edit_active.
  - When it reaches TIMEOUT_S: go to RUN with no start; edit registers keep their values.
- Latency:
  - The mode_btn press in SET_AP is followed by start = 1 on the next cycle.
  - The time-base is loaded on the cycle after that.

Test Plan (TICK_DIV = 4, TIMEOUT_S = 3):
- Reset mid-edit: pulse reset low while in SET_MIN -> state RUN, start never asserted, all outputs at reset values, tick counter restarts (first tick 4 cycles after release).
- Full edit: cur_hours = 11, cur_mins = 58, cur_ap = 0; press mode, inc, mode, inc, inc, mode, inc, mode.
  - Expected: hour 12, minute 0 (58 -> 59 -> 0), ap 1.
  - One-cycle start with hours_load = 11, mins_load = 0, secs_load = 0, ap_load = 1, then RUN.
- Wrap in SET_HR: from edit_hr = 1, dec -> 12, then inc -> 1; in SET_MIN from 0, dec -> 59.
- Timeout: enter SET_HR, apply no buttons for 3 ticks (12 cycles) -> RUN, no start, edit_active = 0, blink = 0.
  - Repeat with an inc press at tick 2: timeout is extended, still in SET_HR after 12 cycles.
- Simultaneous events:
  - mode + inc in SET_HR: advance to SET_MIN with hour unchanged.
  - inc + dec in SET_MIN: minute unchanged, timeout cleared.
- Capture clamp: cur_hours = 0 at mode press -> edit_hr = 12; commit yields hours_load = 11.
